sub_iter: RTL and testbench

//   Parametrised slice-serial subtractor: computes d = a - b - c over WIDTH bits,

---
 rtl/sub_iter.sv | 134 +++++++++++++
 tb/tb_sub_iter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_iter.sv
// sub_iter: slice-serial subtractor d = a - b - c, SLICE bits per clock.
// Optional signed-overflow output enabled by defining SUB_OVF_EN.
module sub_iter #(
  parameter int WIDTH = 64,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             ready,
  output logic [WIDTH-1:0] d,
  output logic             br,
`ifdef SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             done
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             bor_q;
  logic [WIDTH-1:0] d_q;
  logic             br_q;

  logic             accept;
  logic             last;
  logic [SLICE-1:0] a_s, b_s, diff;
  logic             bout;
  logic [WIDTH-1:0] res_nx;
  int               idx;

  assign accept = start && (state_q == S_IDLE);
  assign last   = (cnt_q == LAST);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last)  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready = (state_q == S_IDLE);
    done  = (state_q == S_DONE);
  end

  // One slice of subtraction with borrow, merged into the work result
  always_comb begin
    idx    = int'(cnt_q) * SLICE;
    a_s    = a_q[idx +: SLICE];
    b_s    = b_q[idx +: SLICE];
    {bout, diff} = {1'b0, a_s} - {1'b0, b_s}
                 - {{SLICE{1'b0}}, bor_q};
    res_nx = res_q;
    res_nx[idx +: SLICE] = diff;
  end

  // Work registers: capture on accept, advance one slice per RUN edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      bor_q <= 1'b0;
      cnt_q <= '0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      res_q <= '0;
      bor_q <= c;
      cnt_q <= '0;
    end else if (state_q == S_RUN) begin
      res_q <= res_nx;
      bor_q <= bout;
      cnt_q <= last ? '0 : cnt_q + CW'(1);
    end
  end

  // Result registers: loaded only on the final slice, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q  <= '0;
      br_q <= 1'b0;
    end else if (state_q == S_RUN && last) begin
      d_q  <= res_nx;
      br_q <= bout;
    end
  end

  assign d  = d_q;
  assign br = br_q;

`ifdef SUB_OVF_EN
  logic ovf_q;

  // Signed overflow: operand signs differ and result sign differs from a
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == S_RUN && last) begin
      ovf_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
               (res_nx[WIDTH-1] != a_q[WIDTH-1]);
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_sub_iter.sv
// tb_sub_iter: scoreboard bench for sub_iter (64/4 instance and 8/8).
// Reference model is plain wide arithmetic on whole operands.
module tb_sub_iter;

  localparam int W  = 64;
  localparam int S  = 4;
  localparam int NS = W / S;

  typedef struct {
    logic [W-1:0] d;
    logic         br;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c = 1'b0;
  logic         ready;
  logic [W-1:0] d;
  logic         br;
  logic         done;
  logic         ovf;

  logic         s8_start = 1'b0;
  logic [7:0]   s8_a = '0;
  logic [7:0]   s8_b = '0;
  logic         s8_c = 1'b0;
  logic         s8_ready;
  logic [7:0]   s8_d;
  logic         s8_br;
  logic         s8_done;
  logic         s8_ovf;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  exp_t         sb[$];
  logic [W-1:0] last_d = '0;
  logic         last_br = 1'b0;
  logic         last_ovf = 1'b0;
  logic         done_prev = 1'b0;

`ifndef SUB_OVF_EN
  assign ovf    = 1'b0;
  assign s8_ovf = 1'b0;
`endif

  sub_iter #(.WIDTH(W), .SLICE(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c     (c),
    .ready (ready),
    .d     (d),
    .br    (br),
`ifdef SUB_OVF_EN
    .ovf   (ovf),
`endif
    .done  (done)
  );

  sub_iter #(.WIDTH(8), .SLICE(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (s8_start),
    .a     (s8_a),
    .b     (s8_b),
    .c     (s8_c),
    .ready (s8_ready),
    .d     (s8_d),
    .br    (s8_br),
`ifdef SUB_OVF_EN
    .ovf   (s8_ovf),
`endif
    .done  (s8_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    else
      passes++;
  endtask

  function automatic exp_t model(input logic [W-1:0] ai,
                                 input logic [W-1:0] bi,
                                 input logic ci);
    exp_t m;
    m.d   = ai - bi - W'(ci);
    m.br  = ({1'b0, ai} < ({1'b0, bi} + (W+1)'(ci)));
    m.ovf = (ai[W-1] != bi[W-1]) && (m.d[W-1] != ai[W-1]);
    m.cyc = 0;
    return m;
  endfunction

  // Monitor: pop expected result whenever done is presented
  always @(negedge clk) begin
    if (!rst_n) begin
      done_prev = 1'b0;
      last_d    = '0;
      last_br   = 1'b0;
      last_ovf  = 1'b0;
    end else begin
      if (done_prev) begin
        chk("ready_after_done", W'(ready), W'(1));
        chk("done_one_cycle", W'(done), W'(0));
      end
      if (done) begin
        chk("done_expected", W'(sb.size() != 0), W'(1));
        chk("ready_low_in_done", W'(ready), W'(0));
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("d", d, e.d);
          chk("br", W'(br), W'(e.br));
`ifdef SUB_OVF_EN
          chk("ovf", W'(ovf), W'(e.ovf));
`endif
          chk("latency", W'(cyc), W'(e.cyc));
          last_d   = e.d;
          last_br  = e.br;
          last_ovf = e.ovf;
        end
      end else begin
        chk("d_hold", d, last_d);
        chk("br_hold", W'(br), W'(last_br));
`ifdef SUB_OVF_EN
        chk("ovf_hold", W'(ovf), W'(last_ovf));
`endif
      end
      done_prev = done;
    end
  end

  task automatic do_op(input logic [W-1:0] ai,
                       input logic [W-1:0] bi,
                       input logic ci,
                       output int acc);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      chk("ready_timeout", W'(0), W'(1));
      acc = -1;
      return;
    end
    a = ai;
    b = bi;
    c = ci;
    start = 1'b1;
    e = model(ai, bi, ci);
    e.cyc = cyc + 1 + NS;
    sb.push_back(e);
    acc = cyc + 1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    c = 1'($urandom_range(0, 1));
  endtask

  task automatic op8(input logic [7:0] ai,
                     input logic [7:0] bi,
                     input logic ci);
    logic [7:0] ed;
    logic       ebr;
    logic       eovf;
    ed   = ai - bi - 8'(ci);
    ebr  = ({1'b0, ai} < ({1'b0, bi} + 9'(ci)));
    eovf = (ai[7] != bi[7]) && (ed[7] != ai[7]);
    @(negedge clk);
    chk("s8_ready", W'(s8_ready), W'(1));
    s8_a = ai;
    s8_b = bi;
    s8_c = ci;
    s8_start = 1'b1;
    @(posedge clk);
    #1;
    s8_start = 1'b0;
    s8_a = 8'($urandom);
    s8_b = 8'($urandom);
    @(negedge clk);
    chk("s8_not_early", W'(s8_done), W'(0));
    @(negedge clk);
    chk("s8_done", W'(s8_done), W'(1));
    chk("s8_d", W'(s8_d), W'(ed));
    chk("s8_br", W'(s8_br), W'(ebr));
`ifdef SUB_OVF_EN
    chk("s8_ovf", W'(s8_ovf), W'(eovf));
`endif
    @(negedge clk);
    chk("s8_ready_back", W'(s8_ready), W'(1));
    chk("s8_done_low", W'(s8_done), W'(0));
  endtask

  initial begin
    int acc1;
    int acc2;
    int n;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    #3;
    chk("rst_ready", W'(ready), W'(1));
    chk("rst_done", W'(done), W'(0));
    chk("rst_d", d, W'(0));
    chk("rst_br", W'(br), W'(0));
    chk("rst_ovf", W'(ovf), W'(0));
    #10;
    rst_n = 1'b1;

    do_op(W'(100), W'(58), 1'b0, acc1);
    do_op(W'(0), W'(1), 1'b0, acc1);
    do_op(W'(5), W'(5), 1'b1, acc1);
    do_op(W'(5), W'(4), 1'b1, acc1);
    do_op(64'h8000_0000_0000_0000, W'(1), 1'b0, acc1);
    do_op('1, '1, 1'b1, acc1);

    do_op(W'(7), W'(2), 1'b0, acc1);
    repeat (3) @(negedge clk);
    a = W'(9);
    b = W'(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    do_op(W'(10), W'(4), 1'b0, acc2);
    chk("spacing", W'(acc2 - acc1), W'(NS + 2));

    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
      do_op(ra, rb, 1'($urandom_range(0, 1)), acc1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", W'(sb.size()), W'(0));

    do_op(W'(123), W'(45), 1'b0, acc1);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_ready", W'(ready), W'(1));
    chk("midrun_done", W'(done), W'(0));
    chk("midrun_d", d, W'(0));
    chk("midrun_br", W'(br), W'(0));
    sb.delete();
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    repeat (NS + 6) @(negedge clk);
    chk("no_done_after_abort", W'(done), W'(0));

    op8(8'h10, 8'h01, 1'b0);
    op8(8'h00, 8'h01, 1'b0);
    op8(8'h80, 8'h01, 1'b0);
    for (int i = 0; i < 6; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
